// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage widths, default PC step and FSM encodings for decode/branch logic.
package fetch_unit_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WORD_W = 32;

  localparam logic [ADDR_W-1:0] PC_STEP_DEFAULT = ADDR_W'(4);

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HOLD = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, drives the imem request and pairs each 1-cycle response
// with its PC; stalls via a hold buffer, redirects with a one-cycle bubble.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_addr,
  output logic [ADDR_W-1:0] o_req_addr,
  input  logic [WORD_W-1:0] i_res_data,
  output logic [ADDR_W-1:0] o_pc,
  output logic [WORD_W-1:0] o_instr,
  output logic              o_valid
);

  fetch_state_t      r_state;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_resp_pc;
  logic              r_resp_valid;
  logic [WORD_W-1:0] r_hold;
  logic              advance;
  logic              capture;

  always_ff @(posedge clk) begin
    if (rst) r_state <= FETCH_RUN;
    else     r_state <= state_next;
  end

  // Priority: redirect > stall > advance.
  always_comb begin
    state_next = r_state;
    advance    = 1'b0;
    capture    = 1'b0;
    if (i_redirect) begin
      state_next = FETCH_RUN;
    end else if (i_stall) begin
      if (r_state == FETCH_RUN) begin
        capture    = 1'b1;
        state_next = FETCH_HOLD;
      end
    end else begin
      advance    = 1'b1;
      state_next = FETCH_RUN;
    end
  end

  // Redirect target is forced word-aligned; the in-flight wrong-path response is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc   <= RESET_PC;
      r_resp_pc    <= '0;
      r_resp_valid <= 1'b0;
    end else if (i_redirect) begin
      r_fetch_pc   <= i_redirect_addr & ~ADDR_W'(3);
      r_resp_valid <= 1'b0;
    end else if (advance) begin
      r_resp_pc    <= r_fetch_pc;
      r_resp_valid <= 1'b1;
      r_fetch_pc   <= r_fetch_pc + PC_STEP;
    end
  end

  // imem keeps reading the held address during a stall, so its output must be captured.
  always_ff @(posedge clk) begin
    if (rst)          r_hold <= '0;
    else if (capture) r_hold <= i_res_data;
  end

  assign o_req_addr = r_fetch_pc;
  assign o_pc       = r_resp_pc;
  assign o_valid    = r_resp_valid;
  assign o_instr    = (r_state == FETCH_HOLD) ? r_hold : i_res_data;

endmodule
